dp_mem_clr: RTL and testbench

Parametrised successor to the processor's shared 256×8 instruction/data memory. Port A serves instruction fetch, port B serves data load/store. The single-cycle reset clear of the data region is replaced by a sequential clear engine that can also be re-triggered at run time. Adds busy/drop status and optional parity checking on the data port; sits between the fetch/MEM pipeline stages and the storage array.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/dp_mem_clr_if.sv | 30 +++
 rtl/mem_clear_seq.sv | 72 +++++++
 rtl/dp_mem_clr.sv | 93 +++++++++
 tb/tb_dp_mem_clr.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the dual-port memory with sequential data-region clear:
// FSM encoding, default geometry and a region-membership helper.
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_CLR_BASE = 128;
    localparam int DEF_CLR_END  = 255;

    // Integer compare keeps the bounds check free of width-saturation surprises.
    function automatic logic in_region(input int addr, input int base, input int last);
        return (addr >= base) && (addr <= last);
    endfunction

endpackage

// File: rtl/dp_mem_clr_if.sv
// Port bundle of dp_mem_clr: fetch port A, load/store port B, clear request and status.
// master = pipeline side, slave = memory side.
interface dp_mem_clr_if #(
    parameter int DATA_W = mem_pkg::DEF_DATA_W,
    parameter int ADDR_W = mem_pkg::DEF_ADDR_W
);

    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] data_out_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_out_b;
    logic              we_b;
    logic [DATA_W-1:0] write_data_b;
    logic              clear_req;
    logic              busy;
    logic              wr_drop;
    logic              perr_b;
    logic              perr_sticky;

    modport master (
        output addr_a, addr_b, we_b, write_data_b, clear_req,
        input  data_out_a, data_out_b, busy, wr_drop, perr_b, perr_sticky
    );

    modport slave (
        input  addr_a, addr_b, we_b, write_data_b, clear_req,
        output data_out_a, data_out_b, busy, wr_drop, perr_b, perr_sticky
    );

endinterface

// File: rtl/mem_clear_seq.sv
// Clear engine: walks clr_ptr over [CLR_BASE, CLR_END] one word per cycle, and
// decides whether a port-B write reaches the array or is dropped.
module mem_clear_seq
    import mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CLR_BASE = DEF_CLR_BASE,
    parameter int CLR_END  = DEF_CLR_END
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_b_i,
    input  logic              clear_req_i,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              wr_accept_o,
    output logic              clr_start_o,
    output logic              busy_o,
    output logic              wr_drop_o
);

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(CLR_BASE);
    localparam logic [ADDR_W-1:0] END_A  = ADDR_W'(CLR_END);

    clr_state_e        state_q;
    logic [ADDR_W-1:0] clr_ptr_q;
    logic              busy_q;
    logic              wr_drop_q;

    // Nothing touches the array while reset is held, so a reset edge never clears a word.
    assign clr_we_o    = rst && (state_q == CLEAR);
    assign clr_addr_o  = clr_ptr_q;
    assign clr_start_o = rst && (state_q == READY) && clear_req_i;
    assign wr_accept_o = rst && (state_q == READY) && we_b_i && !clear_req_i;
    assign busy_o      = busy_q;
    assign wr_drop_o   = wr_drop_q;

    // NOTE: state registers use non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= BASE_A;
            busy_q    <= 1'b1;
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= we_b_i && !wr_accept_o;
            case (state_q)
                CLEAR: begin
                    if (clr_ptr_q == END_A) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                    end
                end
                READY: begin
                    if (clear_req_i) begin
                        state_q   <= CLEAR;
                        clr_ptr_q <= BASE_A;
                        busy_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= CLEAR;
                    clr_ptr_q <= BASE_A;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/dp_mem_clr.sv
// Shared instruction/data memory: async-read ports A and B, port-B writes, and a
// sequential clear of the data region. Optional parity on port B via MEM_PARITY_EN.
module dp_mem_clr
    import mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CLR_BASE = DEF_CLR_BASE,
    parameter int CLR_END  = DEF_CLR_END
) (
    input logic         clk,
    input logic         rst,
    dp_mem_clr_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_accept;
    logic              clr_start;
    logic              busy;
    logic              wr_drop;

    logic [DATA_W-1:0] mem_q [DEPTH];

    mem_clear_seq #(
        .ADDR_W  (ADDR_W),
        .CLR_BASE(CLR_BASE),
        .CLR_END (CLR_END)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .we_b_i     (bus.we_b),
        .clear_req_i(bus.clear_req),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .wr_accept_o(wr_accept),
        .clr_start_o(clr_start),
        .busy_o     (busy),
        .wr_drop_o  (wr_drop)
    );

    // NOTE: the array has no reset; only the clear engine zeroes the data region.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_accept) begin
            mem_q[bus.addr_b] <= bus.write_data_b;
        end
    end

    assign bus.data_out_a = mem_q[bus.addr_a];
    assign bus.data_out_b = busy ? '0 : mem_q[bus.addr_b];
    assign bus.busy       = busy;
    assign bus.wr_drop    = wr_drop;

`ifdef MEM_PARITY_EN
    logic par_q [DEPTH];
    logic perr_b;
    logic perr_sticky_q;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_q[clr_addr] <= 1'b0;
        end else if (wr_accept) begin
            par_q[bus.addr_b] <= ^bus.write_data_b;
        end
    end

    assign perr_b = !busy
                 && in_region(int'(bus.addr_b), CLR_BASE, CLR_END)
                 && ((^mem_q[bus.addr_b]) ^ par_q[bus.addr_b]);

    // A fresh clear also re-arms the sticky flag, and wins over a same-cycle error.
    always_ff @(posedge clk) begin
        if (!rst || clr_start) begin
            perr_sticky_q <= 1'b0;
        end else if (perr_b) begin
            perr_sticky_q <= 1'b1;
        end
    end

    assign bus.perr_b      = perr_b;
    assign bus.perr_sticky = perr_sticky_q;
`else
    logic unused_clr_start;
    assign unused_clr_start = clr_start;
    assign bus.perr_b       = 1'b0;
    assign bus.perr_sticky  = 1'b0;
`endif

endmodule

// File: tb/tb_dp_mem_clr.sv
// Directed self-checking bench for dp_mem_clr with default geometry (clear of 128..255).
// Build with MEM_PARITY_EN defined to exercise the parity path.
module tb_dp_mem_clr;

    logic clk;
    logic rst;

    dp_mem_clr_if bus_if ();

    dp_mem_clr dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int clr_cnt;
    int bad_a;
    int bad_b;
    int bad_perr;
    int bad_lo;
    int bad_hi;
    logic chk_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clear cycle, with running checks on what must hold while busy.
    task automatic clr_tick();
        tick();
        clr_cnt++;
        if (bus_if.busy === 1'b1 && bus_if.data_out_b !== 8'h00) bad_b++;
        if (chk_a && bus_if.data_out_a !== 8'hAA) bad_a++;
`ifndef MEM_PARITY_EN
        if (bus_if.perr_b !== 1'b0 || bus_if.perr_sticky !== 1'b0) bad_perr++;
`endif
    endtask

    task automatic wait_idle();
        while (bus_if.busy !== 1'b0 && clr_cnt < 400) clr_tick();
        check("clear_terminates", {31'b0, bus_if.busy}, 32'd0);
    endtask

    task automatic write_b(input logic [7:0] a, input logic [7:0] d);
        bus_if.addr_b       = a;
        bus_if.write_data_b = d;
        bus_if.we_b         = 1'b1;
        tick();
        bus_if.we_b = 1'b0;
    endtask

    initial begin
        rst                 = 1'b0;
        bus_if.addr_a       = 8'd5;
        bus_if.addr_b       = 8'd200;
        bus_if.we_b         = 1'b0;
        bus_if.write_data_b = 8'h00;
        bus_if.clear_req    = 1'b0;
        chk_a               = 1'b0;
        bad_a = 0; bad_b = 0; bad_perr = 0;

        // Reset values
        tick();
        check("rst_busy", {31'b0, bus_if.busy}, 32'd1);
        check("rst_wr_drop", {31'b0, bus_if.wr_drop}, 32'd0);
        check("rst_perr_sticky", {31'b0, bus_if.perr_sticky}, 32'd0);
        check("rst_perr_b", {31'b0, bus_if.perr_b}, 32'd0);
        check("rst_dout_b", {24'b0, bus_if.data_out_b}, 32'h00);
        tick();
        rst     = 1'b1;
        clr_cnt = 0;
        wait_idle();
        check("rst_clear_len", clr_cnt, 128);
        check("rst_clear_dout_b_zero", bad_b, 0);

        // Preload the whole array with 0xAA
        for (int i = 0; i < 256; i++) write_b(8'(i), 8'hAA);
        check("preload_no_drop", {31'b0, bus_if.wr_drop}, 32'd0);

        // clear_req together with a write: write dropped
        bus_if.addr_b       = 8'h90;
        bus_if.write_data_b = 8'h77;
        bus_if.we_b         = 1'b1;
        bus_if.clear_req    = 1'b1;
        tick();
        bus_if.we_b      = 1'b0;
        bus_if.clear_req = 1'b0;
        bus_if.addr_b    = 8'd200;
        bus_if.addr_a    = 8'd5;
        check("req_drop_pulse", {31'b0, bus_if.wr_drop}, 32'd1);
        check("req_busy", {31'b0, bus_if.busy}, 32'd1);
        bad_a = 0; bad_b = 0; chk_a = 1'b1; clr_cnt = 0;
        wait_idle();
        chk_a = 1'b0;
        check("req_clear_len", clr_cnt, 128);
        check("req_fetch_a5_aa", bad_a, 0);
        check("req_dout_b_zero", bad_b, 0);

        // Region sweep through both ports
        bad_lo = 0; bad_hi = 0;
        for (int i = 0; i < 256; i++) begin
            bus_if.addr_a = 8'(i);
            bus_if.addr_b = 8'(i);
            tick();
            if (i < 128) begin
                if (bus_if.data_out_b !== 8'hAA || bus_if.data_out_a !== 8'hAA) bad_lo++;
            end else begin
                if (bus_if.data_out_b !== 8'h00 || bus_if.data_out_a !== 8'h00) bad_hi++;
            end
        end
        check("sweep_instr_region_aa", bad_lo, 0);
        check("sweep_data_region_zero", bad_hi, 0);
        bus_if.addr_b = 8'h90;
        tick();
        check("dropped_write_0x90", {24'b0, bus_if.data_out_b}, 32'h00);

        // READY writes visible on both ports next cycle
        write_b(8'h90, 8'h5C);
        check("wr_0x90_b", {24'b0, bus_if.data_out_b}, 32'h5C);
        check("wr_0x90_no_drop", {31'b0, bus_if.wr_drop}, 32'd0);
        bus_if.addr_a = 8'h90;
        #1;
        check("wr_0x90_a", {24'b0, bus_if.data_out_a}, 32'h5C);
        write_b(8'h10, 8'h33);
        bus_if.addr_a = 8'h10;
        #1;
        check("wr_instr_0x10_a", {24'b0, bus_if.data_out_a}, 32'h33);

        // Clear with a write at cycle 10 and an ignored re-request at cycle 20
        bus_if.addr_a    = 8'd5;
        bus_if.addr_b    = 8'd200;
        bus_if.clear_req = 1'b1;
        tick();
        bus_if.clear_req = 1'b0;
        bad_a = 0; bad_b = 0; chk_a = 1'b1; clr_cnt = 0;
        repeat (9) clr_tick();
        bus_if.addr_b       = 8'h20;
        bus_if.write_data_b = 8'h11;
        bus_if.we_b         = 1'b1;
        clr_tick();
        bus_if.we_b   = 1'b0;
        bus_if.addr_b = 8'd200;
        check("busy_drop_pulse", {31'b0, bus_if.wr_drop}, 32'd1);
        clr_tick();
        check("busy_drop_one_cycle", {31'b0, bus_if.wr_drop}, 32'd0);
        repeat (8) clr_tick();
        bus_if.clear_req = 1'b1;
        clr_tick();
        bus_if.clear_req = 1'b0;
        wait_idle();
        chk_a = 1'b0;
        check("reclear_len_no_restart", clr_cnt, 128);
        check("reclear_fetch_a5_aa", bad_a, 0);
        check("reclear_dout_b_zero", bad_b, 0);
        bus_if.addr_b = 8'h20;
        #1;
        check("busy_write_dropped_0x20", {24'b0, bus_if.data_out_b}, 32'hAA);
        bus_if.addr_b = 8'h90;
        #1;
        check("reclear_0x90_zero", {24'b0, bus_if.data_out_b}, 32'h00);

        // Reset, release, reassert at clear cycle 50
        rst = 1'b0;
        tick();
        check("rst2_busy", {31'b0, bus_if.busy}, 32'd1);
        rst     = 1'b1;
        clr_cnt = 0;
        repeat (50) clr_tick();
        rst = 1'b0;
        tick();
        check("rst_mid_busy", {31'b0, bus_if.busy}, 32'd1);
        rst     = 1'b1;
        clr_cnt = 0;
        wait_idle();
        check("rst_mid_restart_len", clr_cnt, 128);
        bus_if.addr_a = 8'h10;
        #1;
        check("rst_keeps_instr_0x10", {24'b0, bus_if.data_out_a}, 32'h33);

`ifdef MEM_PARITY_EN
        bus_if.addr_b = 8'hA0;
        #1;
        check("par_clean", {31'b0, bus_if.perr_b}, 32'd0);
        dut.mem_q[8'hA0] = dut.mem_q[8'hA0] ^ 8'h01;
        #1;
        check("par_perr_b", {31'b0, bus_if.perr_b}, 32'd1);
        tick();
        check("par_sticky_set", {31'b0, bus_if.perr_sticky}, 32'd1);
        bus_if.clear_req = 1'b1;
        tick();
        bus_if.clear_req = 1'b0;
        check("par_sticky_cleared", {31'b0, bus_if.perr_sticky}, 32'd0);
        clr_cnt = 0;
        wait_idle();
        check("par_after_clear", {31'b0, bus_if.perr_b}, 32'd0);
`else
        check("no_parity_flags", bad_perr, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
